// File: rtl/ct_pkg.sv
// Shared types and default frame geometry for the corner-turn read path.
package ct_pkg;

    localparam int CT_N_RANGE = 2048;
    localparam int CT_N_CHIRP = 32;
    localparam int CT_RD_LAT  = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } ct_rd_state_t;

    typedef struct packed {
        logic tlast;
        logic tuser;
    } ct_side_t;

endpackage

// File: rtl/ct_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head outputs and
// an occupancy count; shared by the corner-turn read and write sides.
module ct_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0] remain, count_nxt;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop        = rd_en && rd_valid;
    assign push       = wr_en && ((count != CNT_W'(DEPTH)) || pop);
    assign remain     = count - CNT_W'(pop);
    assign rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
    assign count_nxt  = remain + CNT_W'(push);

    // NOTE: the storage array carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            rd_valid <= (count_nxt != '0);
            // Head comes from storage if older entries remain, else straight from the write port.
            if (remain != '0)
                rd_data <= mem[rd_ptr_nxt];
            else if (push)
                rd_data <= wr_data;
        end
    end

endmodule

// File: rtl/ct_rd_ctrl.sv
// Corner-turn read controller: drains one frame chirp-major-within-range-bin
// into an AXI-Stream master. Define CT_RD_PINGPONG_EN to honour bank_sel.
module ct_rd_ctrl
    import ct_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int N_RANGE    = CT_N_RANGE,
    parameter int N_CHIRP    = CT_N_CHIRP,
    parameter int RD_LAT     = CT_RD_LAT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bank_sel,
    output logic              busy,
    output logic              done,
    output logic              ram_ren_b,
    output logic [ADDR_W-1:0] ram_raddr_b,
    input  logic [DATA_W-1:0] ram_rdata_b,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              m_tuser
);
    localparam int R_W   = $clog2(N_RANGE);
    localparam int C_W   = $clog2(N_CHIRP);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    ct_rd_state_t      state_q, state_d;
    logic [R_W-1:0]    r_q;
    logic [C_W-1:0]    c_q;
    logic              bank_bit, done_q, done_d, frame_start;
    logic              credit_ok, last_c, last_r, drain_empty, ren;
    logic [RD_LAT-1:0] vld_q;
    ct_side_t          side_q [RD_LAT];
    ct_side_t          side_in, side_out;
    logic [LAT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W+1:0] fifo_rd_data;

    assign last_c      = (c_q == C_W'(N_CHIRP - 1));
    assign last_r      = (r_q == R_W'(N_RANGE - 1));
    assign frame_start = (state_q == IDLE) && start && !done_q;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + LAT_W'(vld_q[i]);
    end

    // Conservative: a pop in this same cycle is not credited back until next cycle.
    assign credit_ok   = (int'(inflight) + int'(fifo_count)) < FIFO_DEPTH;
    assign drain_empty = (fifo_count == '0) ||
                         ((fifo_count == CNT_W'(1)) && m_tvalid && m_tready);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        ren     = 1'b0;
        unique case (state_q)
            IDLE: if (frame_start) state_d = RUN;
            RUN: begin
                ren = credit_ok;
                if (credit_ok && last_c && last_r) state_d = DRAIN;
            end
            DRAIN: begin
                if ((inflight == '0) && drain_empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            r_q     <= '0;
            c_q     <= '0;
            vld_q   <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            vld_q[0] <= ren;
            for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
            if (frame_start) begin
                r_q <= '0;
                c_q <= '0;
            end else if (ren) begin
                c_q <= c_q + C_W'(1);
                if (last_c) r_q <= r_q + R_W'(1);
            end
        end
    end

    assign side_in.tlast = last_c;
    assign side_in.tuser = last_c && last_r;

    always_ff @(posedge clk) begin
        side_q[0] <= side_in;
        for (int i = 1; i < RD_LAT; i++) side_q[i] <= side_q[i-1];
    end

`ifdef CT_RD_PINGPONG_EN
    logic bank_q;
    always_ff @(posedge clk) begin
        if (rst)
            bank_q <= 1'b0;
        else if (frame_start)
            bank_q <= bank_sel;
    end
    assign bank_bit = bank_q;
`else
    logic bank_sel_unused;
    assign bank_sel_unused = bank_sel;
    assign bank_bit        = 1'b0;
`endif

    assign ram_ren_b   = ren;
    assign ram_raddr_b = {bank_bit, (ADDR_W-1)'({c_q, r_q})};

    ct_sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (vld_q[RD_LAT-1]),
        .wr_data  ({side_q[RD_LAT-1], ram_rdata_b}),
        .rd_en    (m_tready),
        .rd_data  (fifo_rd_data),
        .rd_valid (m_tvalid),
        .count    (fifo_count)
    );

    assign {side_out, m_tdata} = fifo_rd_data;
    assign m_tlast = side_out.tlast;
    assign m_tuser = side_out.tuser;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_ct_rd_ctrl.sv
// Self-checking bench for ct_rd_ctrl on a reduced 64x8 frame with a
// latency-2 RAM model holding data = address.
module tb_ct_rd_ctrl;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 32;
    localparam int N_RANGE    = 64;
    localparam int N_CHIRP    = 8;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int TOTAL      = N_RANGE * N_CHIRP;
    localparam int BUDGET     = 4 * TOTAL + 200;
`ifdef CT_RD_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, start, bank_sel, busy, done, ram_ren_b;
    logic [ADDR_W-1:0] ram_raddr_b;
    logic [DATA_W-1:0] ram_rdata_b, m_tdata;
    logic              m_tvalid, m_tready, m_tlast, m_tuser;

    always #5 clk = ~clk;

    ct_rd_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RANGE(N_RANGE),
        .N_CHIRP(N_CHIRP), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel),
        .busy(busy), .done(done), .ram_ren_b(ram_ren_b),
        .ram_raddr_b(ram_raddr_b), .ram_rdata_b(ram_rdata_b),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser)
    );

    // RAM model: data = address, enable-gated first stage, free-running second stage.
    logic [DATA_W-1:0] ram_q1, ram_q2;
    always @(posedge clk) begin
        if (ram_ren_b) ram_q1 <= DATA_W'(ram_raddr_b);
        ram_q2 <= ram_q1;
    end
    assign ram_rdata_b = ram_q2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat k of a frame is range bin k/N_CHIRP, chirp k%N_CHIRP.
    function automatic logic [ADDR_W-1:0] exp_addr(input int k, input logic bank);
        int c = k % N_CHIRP;
        int r = k / N_CHIRP;
        return {bank, (ADDR_W-1)'(c * N_RANGE + r)};
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input int k, input logic bank);
        return DATA_W'(exp_addr(k, bank));
    endfunction

    function automatic logic exp_last(input int k);
        return (k % N_CHIRP) == N_CHIRP - 1;
    endfunction

    function automatic logic exp_user(input int k);
        return k == TOTAL - 1;
    endfunction

    // Ready pattern: 0 = always, 1 = one cycle in three, 2 = held low.
    int rdy_mode = 0;
    int rdy_cyc  = 0;
    always @(posedge clk) begin
        #2;
        rdy_cyc++;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (rdy_cyc % 3 == 0);
            default: m_tready = 1'b0;
        endcase
    end

    logic              model_busy = 1'b0, model_bank = 1'b0;
    logic              tuser_hs_prev = 1'b0, stall_prev = 1'b0, seen_valid = 1'b0;
    logic              cmp_hs, cmp_idle;
    logic [DATA_W-1:0] hold_data, first_beat_data;
    logic [1:0]        hold_side;
    int                read_idx = 0, beat_idx = 0, frame_cyc = 0, last_beat_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            model_busy    = 1'b0;
            tuser_hs_prev = 1'b0;
            stall_prev    = 1'b0;
            seen_valid    = 1'b0;
            read_idx      = 0;
            beat_idx      = 0;
            frame_cyc     = 0;
        end else begin
            frame_cyc++;
            cmp_idle = !model_busy && !tuser_hs_prev;
            check("busy", busy, model_busy);
            check("done", done, tuser_hs_prev);
            if (!model_busy) check("idle_tvalid", m_tvalid, 1'b0);
            if (stall_prev) begin
                check("stall_tvalid", m_tvalid, 1'b1);
                check("stall_tdata", m_tdata, hold_data);
                check("stall_side", {m_tlast, m_tuser}, hold_side);
            end
            if (ram_ren_b) begin
                check("read_in_frame", model_busy && read_idx < TOTAL, 1'b1);
                if (read_idx == 0) check("first_read_cyc", frame_cyc, 1);
                check("raddr", ram_raddr_b, exp_addr(read_idx, model_bank));
                check("credit", (read_idx + 1 - beat_idx) <= FIFO_DEPTH, 1'b1);
                read_idx++;
            end
            if (m_tvalid && !seen_valid && model_busy) begin
                check("first_valid_cyc", frame_cyc, 4);
                seen_valid = 1'b1;
            end
            cmp_hs = m_tvalid && m_tready;
            if (cmp_hs) begin
                check("beat_in_frame", model_busy && beat_idx < TOTAL, 1'b1);
                check("tdata", m_tdata, exp_data(beat_idx, model_bank));
                check("tlast", m_tlast, exp_last(beat_idx));
                check("tuser", m_tuser, exp_user(beat_idx));
                if (beat_idx == 0) first_beat_data = m_tdata;
                last_beat_cyc = frame_cyc;
                beat_idx++;
            end
            tuser_hs_prev = cmp_hs && model_busy && (beat_idx == TOTAL);
            if (tuser_hs_prev) model_busy = 1'b0;
            stall_prev = m_tvalid && !m_tready;
            hold_data  = m_tdata;
            hold_side  = {m_tlast, m_tuser};
            if (start && cmp_idle) begin
                model_busy = 1'b1;
                model_bank = PP ? bank_sel : 1'b0;
                read_idx   = 0;
                beat_idx   = 0;
                frame_cyc  = 0;
                seen_valid = 1'b0;
            end
        end
    end

    task automatic start_frame(input logic bank);
        bank_sel = bank;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        bank_sel = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic got = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check(name, got, 1'b1);
    endtask

    task automatic wait_beats(input string name, input int n);
        for (int i = 0; i < BUDGET; i++) begin
            if (beat_idx >= n) break;
            tick();
        end
        check(name, beat_idx >= n, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        bank_sel = 1'b0;
        m_tready = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ren", ram_ren_b, 1'b0);
        check("rst_raddr", ram_raddr_b, 0);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_tuser", m_tuser, 1'b0);
        check("rst_tdata", m_tdata, 0);
        rst = 1'b0;
        tick();

        check("pin_beat1", exp_data(1, 1'b0), 64);
        check("pin_beat9", exp_data(9, 1'b0), 65);
        check("pin_beat_last", exp_data(TOTAL - 1, 1'b0), 511);
        check("pin_bank_addr", exp_addr(0, 1'b1), 64'h10000);
        check("pin_tlast7", exp_last(7), 1'b1);
        check("pin_tlast8", exp_last(8), 1'b0);

        // Full throughput, then a start in the done cycle that must be ignored.
        rdy_mode = 0;
        tick();
        start_frame(1'b0);
        wait_done("t1_done");
        check("t1_beats", beat_idx, TOTAL);
        check("t1_last_beat_cyc", last_beat_cyc, 4 + TOTAL - 1);
        check("t1_beat0", first_beat_data, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_start_in_done", busy, 1'b0);
        repeat (5) tick();

        // One-in-three backpressure on bank 1.
        rdy_mode = 1;
        tick();
        start_frame(1'b1);
        wait_done("t3_done");
        check("t3_beats", beat_idx, TOTAL);
        check("t3_beat0", first_beat_data, PP ? 64'h10000 : 64'h0);
        repeat (5) tick();

        // Held stall: reads stop once the credit window is full.
        rdy_mode = 2;
        tick();
        start_frame(1'b0);
        repeat (50) tick();
        check("t4_reads_stalled", read_idx, FIFO_DEPTH);
        check("t4_beats_stalled", beat_idx, 0);
        rdy_mode = 0;
        wait_done("t4_done");
        check("t4_beats", beat_idx, TOTAL);
        repeat (5) tick();

        // Second start mid-frame is ignored.
        start_frame(1'b0);
        wait_beats("t5_reach10", 10);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t5_done");
        check("t5_beats", beat_idx, TOTAL);
        repeat (20) tick();
        check("t5_no_extra", beat_idx, TOTAL);

        // Reset mid-frame, then a clean frame.
        start_frame(1'b0);
        wait_beats("t6_reach100", 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_tvalid", m_tvalid, 1'b0);
        check("t6_busy", busy, 1'b0);
        repeat (5) tick();
        start_frame(1'b0);
        wait_done("t6_done");
        check("t6_beat0", first_beat_data, 0);
        check("t6_beats", beat_idx, TOTAL);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
